// File: rtl/rep3_adder.sv
// rep3_adder: full-adder slice (sum x, carry y of a, b, c) that can also be
// reused LSB-first over WIDTH clock edges to add two serial words.
module rep3_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             ser_en,
    output logic             x,
    output logic             y,
    output logic             xq,
    output logic             yq,
    output logic [WIDTH-1:0] sum_word,
    output logic             cout,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             cin;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             xq_q, yq_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    // Bit 0 of every serial word, and every plain-adder use, takes c as carry-in.
    assign cin = (ser_en && cnt_q != '0) ? cy_q : c;
    assign x   = a ^ b ^ cin;
    assign y   = (a & b) | (a & cin) | (b & cin);

    always_comb begin
        cy_d   = cy_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        done_d = 1'b0;
        if (ser_en) begin
            cy_d  = y;
            sum_d = {x, sum_q[WIDTH-1:1]};
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                cout_d = y;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            // Leaving serial mode abandons any partial word; sum and cout hold.
            cnt_d = '0;
            cy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xq_q   <= 1'b0;
            yq_q   <= 1'b0;
            cy_q   <= 1'b0;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            xq_q   <= x;
            yq_q   <= y;
            cy_q   <= cy_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            done_q <= done_d;
        end
    end

    assign xq       = xq_q;
    assign yq       = yq_q;
    assign sum_word = sum_q;
    assign cout     = cout_q;
    assign done     = done_q;
endmodule

// File: tb/tb_rep3_adder.sv
// Bench for rep3_adder: arithmetic word model checked every clock, plus
// directed vectors with hand-computed results.
module tb_rep3_adder;
    localparam int W = 8;

    logic         clk, rst, a, b, c, ser_en;
    logic         x, y, xq, yq, cout, done;
    logic [W-1:0] sum_word;
    logic         run;

    int total = 0;
    int bad   = 0;
    int n_done = 0;

    // Model state: word bits seen so far, as integers.
    int           m_idx, m_a, m_b, m_cin0, m_full;
    logic         m_xq, m_yq, m_done, m_cout;
    logic [W-1:0] m_sum;

    rep3_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .ser_en(ser_en),
        .x(x), .y(y), .xq(xq), .yq(yq), .sum_word(sum_word),
        .cout(cout), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (run) clk = ~clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {y, x}: carry into the current bit comes from the integer sum of
    // the bits already consumed, not from any stored carry bit.
    function automatic logic [1:0] model_xy();
        int cin_v, s;
        if (ser_en && m_idx != 0) cin_v = ((m_a + m_b + m_cin0) >> m_idx) & 1;
        else                      cin_v = int'(c);
        s = int'(a) + int'(b) + cin_v;
        return 2'(s);
    endfunction

    task automatic model_reset();
        m_idx = 0; m_a = 0; m_b = 0; m_cin0 = 0; m_full = 0;
        m_xq = 0; m_yq = 0; m_done = 0; m_cout = 0; m_sum = '0;
    endtask

    task automatic model_step();
        logic [1:0] xy;
        xy   = model_xy();
        m_xq = xy[0];
        m_yq = xy[1];
        if (ser_en) begin
            if (m_idx == 0) m_cin0 = int'(c);
            m_a   = m_a | (int'(a) << m_idx);
            m_b   = m_b | (int'(b) << m_idx);
            m_sum = {xy[0], m_sum[W-1:1]};
            if (m_idx == W - 1) begin
                m_full = m_a + m_b + m_cin0;
                m_cout = xy[1];
                m_done = 1'b1;
                m_idx = 0; m_a = 0; m_b = 0;
            end else begin
                m_idx++;
                m_done = 1'b0;
            end
        end else begin
            m_idx = 0; m_a = 0; m_b = 0;
            m_done = 1'b0;
        end
    endtask

    // Compare process: one full check just after every clock edge or reset.
    initial begin
        model_reset();
        forever begin
            logic [1:0] xy;
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
            #1;
            xy = model_xy();
            chk("x", x, xy[0]);
            chk("y", y, xy[1]);
            chk("xq", xq, m_xq);
            chk("yq", yq, m_yq);
            chk("done", done, m_done);
            chk("cout", cout, m_cout);
            chk("sum_word", sum_word, m_sum);
            if (m_done) chk("word_value", {cout, sum_word}, m_full[W:0]);
            if (!rst && done) n_done++;
        end
    end

    task automatic step(input logic ia, input logic ib, input logic ic, input logic ien);
        @(negedge clk);
        a = ia; b = ib; c = ic; ser_en = ien;
    endtask

    task automatic serial_word(input logic [W-1:0] wa, input logic [W-1:0] wb, input logic cin0);
        for (int i = 0; i < W; i++)
            step(wa[i], wb[i], (i == 0) ? cin0 : 1'b0, 1'b1);
        @(posedge clk);
        #2;
    endtask

    logic [1:0] comb_exp [8];

    initial begin
        // {x, y} for abc = 000 .. 111
        comb_exp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        run = 1'b0; rst = 1'b0;
        a = 0; b = 0; c = 0; ser_en = 0;
        #1 rst = 1'b1;
        #2;
        chk("rst_xq", xq, 0);
        chk("rst_yq", yq, 0);
        chk("rst_sum", sum_word, 0);
        chk("rst_cout", cout, 0);
        chk("rst_done", done, 0);

        // Combinational sweep with no clock and reset held.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            {a, b, c} = abc;
            #1;
            chk("comb_x", x, comb_exp[i][1]);
            chk("comb_y", y, comb_exp[i][0]);
            #4;
        end
        rst = 1'b0;
        run = 1'b1;

        // Registered path.
        step(1, 1, 0, 0);
        @(posedge clk); #2;
        chk("reg110_xq", xq, 0);
        chk("reg110_yq", yq, 1);
        chk("reg110_done", done, 0);
        step(1, 1, 1, 0);
        @(posedge clk); #2;
        chk("reg111_xq", xq, 1);
        chk("reg111_yq", yq, 1);
        chk("reg111_done", done, 0);
        step(0, 0, 0, 0);

        // 0xB5 + 0x4E = 0x103
        serial_word(8'hB5, 8'h4E, 1'b0);
        chk("w1_sum", sum_word, 8'h03);
        chk("w1_cout", cout, 1);
        chk("w1_done", done, 1);
        step(0, 0, 0, 0);

        // 0xFF + 0x00 + 1 = 0x100, then 0x01 + 0x01 back-to-back.
        serial_word(8'hFF, 8'h00, 1'b1);
        chk("w2_sum", sum_word, 8'h00);
        chk("w2_cout", cout, 1);
        chk("w2_done", done, 1);
        serial_word(8'h01, 8'h01, 1'b0);
        chk("w3_sum", sum_word, 8'h02);
        chk("w3_cout", cout, 0);
        chk("w3_done", done, 1);
        step(0, 0, 0, 0);
        @(posedge clk); #2;
        chk("w3_done_gone", done, 0);

        // Reset after 3 bits of 0x07 + 0x03, asserted between edges.
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] ra, rb;
            ra = 8'h07; rb = 8'h03;
            step(ra[i], rb[i], 1'b0, 1'b1);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_xq", xq, 0);
        chk("mid_rst_yq", yq, 0);
        chk("mid_rst_sum", sum_word, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0; a = 0; b = 0; c = 0; ser_en = 0;
        serial_word(8'h10, 8'h20, 1'b0);
        chk("w4_sum", sum_word, 8'h30);
        chk("w4_cout", cout, 0);
        chk("w4_done", done, 1);
        step(0, 0, 0, 0);

        // Abort after bits 0..4 of 0x55 + 0x33, then a fresh word.
        for (int i = 0; i < 5; i++) begin
            logic [W-1:0] pa, pb;
            pa = 8'h55; pb = 8'h33;
            step(pa[i], pb[i], 1'b0, 1'b1);
        end
        step(0, 0, 0, 0);
        @(posedge clk); #2;
        chk("abort_done", done, 0);
        chk("abort_cout_held", cout, 0);
        // 0xC3 + 0x7E + 1 = 0x142
        serial_word(8'hC3, 8'h7E, 1'b1);
        chk("w5_sum", sum_word, 8'h42);
        chk("w5_cout", cout, 1);
        chk("w5_done", done, 1);
        step(0, 0, 0, 0);
        @(posedge clk); #2;
        chk("w5_done_gone", done, 0);
        chk("done_pulses", n_done, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
